// File: rtl/vga_colproc_pkg.sv
// Shared types and helpers for the parametrised VGA colour processor.
//   colordepth_e  : pixel format selector (8/16/24/32 bpp)
//   state_e       : pseudo-colour CLUT handshake states
//   bpp()         : bytes consumed per pixel for a colour depth
//   rgb565_expand : RGB565 to RGB888 with MSB replication into the low bits
package vga_colproc_pkg;

  typedef enum logic [1:0] {
    CD_8  = 2'd0,
    CD_16 = 2'd1,
    CD_24 = 2'd2,
    CD_32 = 2'd3
  } colordepth_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic [2:0] bpp(input colordepth_e cd);
    case (cd)
      CD_8:    return 3'd1;
      CD_16:   return 3'd2;
      CD_24:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // Replicating the top bits keeps full-scale 5/6-bit values at 0xFF.
  function automatic logic [23:0] rgb565_expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/vga_byte_unpacker.sv
// Byte buffer between the video-word FIFO and the pixel converter.
// Holds up to two words of bytes, oldest byte at index 0, and exposes the
// four oldest bytes to the converter.
//   clk_i, nrst_i : clock, asynchronous active-low reset
//   srst_i        : synchronous clear (empties the buffer)
//   word_i        : head word of the video FIFO, MSB byte is oldest
//   empty_i       : video FIFO empty
//   pop_i         : bytes consumed by the converter this cycle (0..4)
//   rreq_o        : pop the video FIFO head word this cycle
//   cnt_o         : bytes currently held
//   byte0_o..3_o  : oldest four bytes
module vga_byte_unpacker #(
  parameter int DATA_W = 32
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          srst_i,
  input  logic [DATA_W-1:0]             word_i,
  input  logic                          empty_i,
  input  logic [2:0]                    pop_i,
  output logic                          rreq_o,
  output logic [$clog2(DATA_W/4+1)-1:0] cnt_o,
  output logic [7:0]                    byte0_o,
  output logic [7:0]                    byte1_o,
  output logic [7:0]                    byte2_o,
  output logic [7:0]                    byte3_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 * NB;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [7:0]    bytes_q [DEPTH];
  logic [7:0]    bytes_d [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A new word is accepted whenever it fits after this cycle's consumption,
  // so a pixel straddling two words never costs a bubble.
  always_comb begin
    rreq_o = !empty_i && !srst_i &&
             ((int'(cnt_q) + NB - int'(pop_i)) <= DEPTH);
  end

  // Shift out the consumed bytes, then append the incoming word behind the
  // survivors. Slots past the fill level are zeroed.
  always_comb begin
    int cntI;
    int popI;
    int keepI;
    cntI  = int'(cnt_q);
    popI  = int'(pop_i);
    keepI = cntI - popI;
    for (int i = 0; i < DEPTH; i++) begin
      bytes_d[i] = 8'h00;
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j == i + popI) && (j < cntI)) begin
          bytes_d[i] = bytes_q[j];
        end
      end
    end
    if (rreq_o) begin
      for (int k = 0; k < NB; k++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == keepI + k) begin
            bytes_d[i] = word_i[DATA_W-1-8*k -: 8];
          end
        end
      end
      cnt_d = CW'(keepI + NB);
    end else begin
      cnt_d = CW'(keepI);
    end
  end

  // Buffer storage and fill level.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) bytes_q[i] <= 8'h00;
    end else if (srst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) bytes_q[i] <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign byte0_o = bytes_q[0];
  assign byte1_o = bytes_q[1];
  assign byte2_o = bytes_q[2];
  assign byte3_o = bytes_q[3];

endmodule

// File: rtl/vga_colproc_param.sv
// Parametrised VGA colour processor: unpacks video words into 8/16/24/32 bpp
// pixels and writes 24-bit RGB to the RGB FIFO. 8bpp pseudo-colour goes
// through a request/acknowledge CLUT port of arbitrary latency.
//   clk, nrst, srst          : clock, async active-low reset, sync clear
//   ColorDepth, PseudoColor  : static pixel format selection
//   vdat_buffer_*            : show-ahead video word FIFO read side
//   rgb_fifo_full/_wreq, r/g/b : RGB FIFO write side (registered)
//   clut_req/offs/ack/q      : colour lookup table handshake
module vga_colproc_param
  import vga_colproc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              srst,
  input  logic [1:0]        ColorDepth,
  input  logic              PseudoColor,
  input  logic [DATA_W-1:0] vdat_buffer_di,
  input  logic              vdat_buffer_empty,
  output logic              vdat_buffer_rreq,
  input  logic              rgb_fifo_full,
  output logic              rgb_fifo_wreq,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              clut_req,
  output logic [7:0]        clut_offs,
  input  logic              clut_ack,
  input  logic [23:0]       clut_q
);

  localparam int CW = $clog2(DATA_W / 4 + 1);

  colordepth_e   cd;
  logic          pseudo;
  logic [2:0]    bppW;
  logic [2:0]    pop;
  logic [CW-1:0] cnt;
  logic [7:0]    byte0, byte1, byte2, byte3;
  logic [23:0]   pix;

  state_e        state_q, state_d;
  logic          clut_req_q, clut_req_d;
  logic [7:0]    clut_offs_q, clut_offs_d;
  logic          wreq_q, wreq_d;
  logic [23:0]   rgb_q, rgb_d;

  assign cd     = colordepth_e'(ColorDepth);
  assign pseudo = (cd == CD_8) && PseudoColor;
  assign bppW   = bpp(cd);

  vga_byte_unpacker #(.DATA_W(DATA_W)) u_unpacker (
    .clk_i   (clk),
    .nrst_i  (nrst),
    .srst_i  (srst),
    .word_i  (vdat_buffer_di),
    .empty_i (vdat_buffer_empty),
    .pop_i   (pop),
    .rreq_o  (vdat_buffer_rreq),
    .cnt_o   (cnt),
    .byte0_o (byte0),
    .byte1_o (byte1),
    .byte2_o (byte2),
    .byte3_o (byte3)
  );

  // Direct-mode pixel conversion from the oldest bytes in the buffer.
  always_comb begin
    case (cd)
      CD_8:    pix = {byte0, byte0, byte0};
      CD_16:   pix = rgb565_expand({byte0, byte1});
      CD_24:   pix = {byte0, byte1, byte2};
      default: pix = {byte1, byte2, byte3};
    endcase
  end

  // Next-state logic: srst wins over everything, then either the CLUT
  // handshake FSM (8bpp pseudo-colour) or one direct pixel per cycle.
  // FIFO full is only checked when a CLUT request starts; the FIFO's slack
  // absorbs the pixel that completes while waiting.
  always_comb begin
    state_d     = state_q;
    clut_req_d  = clut_req_q;
    clut_offs_d = clut_offs_q;
    wreq_d      = 1'b0;
    rgb_d       = rgb_q;
    pop         = 3'd0;
    if (srst) begin
      state_d     = IDLE;
      clut_req_d  = 1'b0;
      clut_offs_d = 8'h00;
      rgb_d       = 24'h0;
    end else if (pseudo) begin
      case (state_q)
        IDLE: begin
          if ((int'(cnt) >= 1) && !rgb_fifo_full) begin
            pop         = 3'd1;
            clut_offs_d = byte0;
            clut_req_d  = 1'b1;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (clut_ack) begin
            clut_req_d = 1'b0;
            rgb_d      = clut_q;
            wreq_d     = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((int'(cnt) >= int'(bppW)) && !rgb_fifo_full) begin
      pop    = bppW;
      wreq_d = 1'b1;
      rgb_d  = pix;
    end
  end

  // Registered outputs and FSM state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      clut_req_q  <= 1'b0;
      clut_offs_q <= 8'h00;
      wreq_q      <= 1'b0;
      rgb_q       <= 24'h0;
    end else begin
      state_q     <= state_d;
      clut_req_q  <= clut_req_d;
      clut_offs_q <= clut_offs_d;
      wreq_q      <= wreq_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb_fifo_wreq = wreq_q;
  assign r             = rgb_q[23:16];
  assign g             = rgb_q[15:8];
  assign b             = rgb_q[7:0];
  assign clut_req      = clut_req_q;
  assign clut_offs     = clut_offs_q;

endmodule

// File: tb/tb_vga_colproc_param.sv
// Directed self-checking bench for vga_colproc_param with DATA_W=32.
// The video FIFO is modelled as a word queue popped on rreq.
module tb_vga_colproc_param;

  logic        clk;
  logic        nrst;
  logic        srst;
  logic [1:0]  ColorDepth;
  logic        PseudoColor;
  logic [31:0] vdat_buffer_di;
  logic        vdat_buffer_empty;
  logic        vdat_buffer_rreq;
  logic        rgb_fifo_full;
  logic        rgb_fifo_wreq;
  logic [7:0]  r, g, b;
  logic        clut_req;
  logic [7:0]  clut_offs;
  logic        clut_ack;
  logic [23:0] clut_q;

  int          total;
  int          bad;
  logic [31:0] vq[$];
  logic        popNow;

  vga_colproc_param #(.DATA_W(32)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .srst              (srst),
    .ColorDepth        (ColorDepth),
    .PseudoColor       (PseudoColor),
    .vdat_buffer_di    (vdat_buffer_di),
    .vdat_buffer_empty (vdat_buffer_empty),
    .vdat_buffer_rreq  (vdat_buffer_rreq),
    .rgb_fifo_full     (rgb_fifo_full),
    .rgb_fifo_wreq     (rgb_fifo_wreq),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .clut_req          (clut_req),
    .clut_offs         (clut_offs),
    .clut_ack          (clut_ack),
    .clut_q            (clut_q)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refreshVid();
    vdat_buffer_empty = (vq.size() == 0);
    vdat_buffer_di    = (vq.size() == 0) ? 32'h0 : vq[0];
  endtask

  task automatic pushWord(input logic [31:0] w);
    vq.push_back(w);
    refreshVid();
  endtask

  // One clock: note rreq at the falling edge, pass the rising edge, then
  // retire the popped word. Returns 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    popNow = vdat_buffer_rreq;
    @(posedge clk);
    #1;
    if (popNow && vq.size() > 0) void'(vq.pop_front());
    refreshVid();
  endtask

  task automatic setMode(input logic [1:0] cd, input logic pc);
    srst        = 1'b1;
    ColorDepth  = cd;
    PseudoColor = pc;
    step();
    srst        = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    total++;
    if (rgb_fifo_wreq !== 1'b0 || clut_req !== 1'b0 || {r, g, b} !== 24'h0 || clut_offs !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset: wreq=%b req=%b rgb=%h offs=%h expected all zero", rgb_fifo_wreq, clut_req, {r, g, b}, clut_offs);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0 || vdat_buffer_rreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: wreq=%b rreq=%b expected 0 0", rgb_fifo_wreq, vdat_buffer_rreq);
    end
  endtask

  task automatic test_grey8();
    logic [7:0] expB [4];
    expB = '{8'h11, 8'h22, 8'h33, 8'h44};
    setMode(2'd0, 1'b0);
    pushWord(32'h11223344);
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL grey8_lat: wreq=%b expected 0", rgb_fifo_wreq);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== {expB[i], expB[i], expB[i]}) begin
        bad++;
        $display("[TB] FAIL grey8[%0d]: wreq=%b rgb=%h expected 1 %h", i, rgb_fifo_wreq, {r, g, b}, {expB[i], expB[i], expB[i]});
      end
    end
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL grey8_end: wreq=%b expected 0", rgb_fifo_wreq);
    end
  endtask

  task automatic test_rgb565();
    logic [23:0] expP [4];
    expP = '{24'hFF0000, 24'h00FF00, 24'h000000, 24'h0000FF};
    setMode(2'd1, 1'b0);
    pushWord(32'hF80007E0);
    pushWord(32'h0000001F);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== expP[i]) begin
        bad++;
        $display("[TB] FAIL rgb565[%0d]: wreq=%b rgb=%h expected 1 %h", i, rgb_fifo_wreq, {r, g, b}, expP[i]);
      end
    end
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rgb565_end: wreq=%b expected 0", rgb_fifo_wreq);
    end
  endtask

  task automatic test_rgb24_straddle();
    logic [23:0] expP [4];
    expP = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    setMode(2'd2, 1'b0);
    pushWord(32'h11223344);
    pushWord(32'h55667788);
    pushWord(32'h99AABBCC);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== expP[i]) begin
        bad++;
        $display("[TB] FAIL rgb24[%0d]: wreq=%b rgb=%h expected 1 %h", i, rgb_fifo_wreq, {r, g, b}, expP[i]);
      end
    end
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rgb24_end: wreq=%b expected 0", rgb_fifo_wreq);
    end
  endtask

  task automatic test_xrgb32();
    setMode(2'd3, 1'b0);
    pushWord(32'hEE123456);
    step();
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== 24'h123456) begin
      bad++;
      $display("[TB] FAIL xrgb32: wreq=%b rgb=%h expected 1 123456", rgb_fifo_wreq, {r, g, b});
    end
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL xrgb32_end: wreq=%b expected 0", rgb_fifo_wreq);
    end
  endtask

  task automatic test_pseudo_clut();
    setMode(2'd0, 1'b1);
    pushWord(32'h05000000);
    step();
    total++;
    if (clut_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clut_pre: req=%b expected 0", clut_req);
    end
    // Request held for three cycles with a stable index.
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (clut_req !== 1'b1 || clut_offs !== 8'h05 || rgb_fifo_wreq !== 1'b0) begin
        bad++;
        $display("[TB] FAIL clut_wait[%0d]: req=%b offs=%h wreq=%b expected 1 05 0", i, clut_req, clut_offs, rgb_fifo_wreq);
      end
    end
    clut_ack = 1'b1;
    clut_q   = 24'hABCDEF;
    step();
    clut_ack = 1'b0;
    total++;
    if (clut_req !== 1'b0 || rgb_fifo_wreq !== 1'b1 || {r, g, b} !== 24'hABCDEF) begin
      bad++;
      $display("[TB] FAIL clut_ack: req=%b wreq=%b rgb=%h expected 0 1 abcdef", clut_req, rgb_fifo_wreq, {r, g, b});
    end
    step();
    total++;
    if (clut_req !== 1'b1 || clut_offs !== 8'h00 || rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clut_req2: req=%b offs=%h wreq=%b expected 1 00 0", clut_req, clut_offs, rgb_fifo_wreq);
    end
    // Acknowledge in the first cycle the request is visible.
    clut_ack = 1'b1;
    clut_q   = 24'h123456;
    step();
    clut_ack = 1'b0;
    total++;
    if (clut_req !== 1'b0 || rgb_fifo_wreq !== 1'b1 || {r, g, b} !== 24'h123456) begin
      bad++;
      $display("[TB] FAIL clut_fastack: req=%b wreq=%b rgb=%h expected 0 1 123456", clut_req, rgb_fifo_wreq, {r, g, b});
    end
    step();
    total++;
    if (clut_req !== 1'b1 || rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clut_req3: req=%b wreq=%b expected 1 0", clut_req, rgb_fifo_wreq);
    end
    // Clear during WAIT; the late acknowledge must be ignored and the one
    // byte left in the buffer must be gone.
    srst = 1'b1;
    step();
    srst = 1'b0;
    total++;
    if (clut_req !== 1'b0 || rgb_fifo_wreq !== 1'b0 || clut_offs !== 8'h00 || {r, g, b} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL clut_srst: req=%b wreq=%b offs=%h rgb=%h expected 0 0 00 0", clut_req, rgb_fifo_wreq, clut_offs, {r, g, b});
    end
    clut_ack = 1'b1;
    clut_q   = 24'hFFFFFF;
    step();
    clut_ack = 1'b0;
    total++;
    if (clut_req !== 1'b0 || rgb_fifo_wreq !== 1'b0 || {r, g, b} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL clut_lateack: req=%b wreq=%b rgb=%h expected 0 0 0", clut_req, rgb_fifo_wreq, {r, g, b});
    end
  endtask

  task automatic test_fifo_full();
    int          idx;
    logic        fullSeen;
    logic [23:0] expPix;
    idx = 0;
    setMode(2'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pushWord({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
    end
    for (int i = 0; i < 22; i++) begin
      if (i == 3) rgb_fifo_full = 1'b1;
      if (i == 8) rgb_fifo_full = 1'b0;
      fullSeen = rgb_fifo_full;
      step();
      if (fullSeen) begin
        total++;
        if (rgb_fifo_wreq !== 1'b0) begin
          bad++;
          $display("[TB] FAIL full_stall[%0d]: wreq=%b expected 0", i, rgb_fifo_wreq);
        end
      end
      if (rgb_fifo_wreq === 1'b1) begin
        expPix = {8'(3*idx+1), 8'(3*idx+2), 8'(3*idx+3)};
        total++;
        if ({r, g, b} !== expPix) begin
          bad++;
          $display("[TB] FAIL full_order[%0d]: rgb=%h expected %h", idx, {r, g, b}, expPix);
        end
        idx++;
      end
    end
    total++;
    if (idx != 8) begin
      bad++;
      $display("[TB] FAIL full_count: pixels=%0d expected 8", idx);
    end
  endtask

  task automatic test_srst_midstream();
    setMode(2'd2, 1'b0);
    pushWord(32'h11223344);
    pushWord(32'h55667788);
    pushWord(32'h99AABBCC);
    step();
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== 24'h112233) begin
      bad++;
      $display("[TB] FAIL srst_pre: wreq=%b rgb=%h expected 1 112233", rgb_fifo_wreq, {r, g, b});
    end
    srst = 1'b1;
    step();
    srst = 1'b0;
    total++;
    if (rgb_fifo_wreq !== 1'b0 || {r, g, b} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL srst_clear: wreq=%b rgb=%h expected 0 0", rgb_fifo_wreq, {r, g, b});
    end
    step();
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== 24'h99AABB) begin
      bad++;
      $display("[TB] FAIL srst_resume: wreq=%b rgb=%h expected 1 99aabb", rgb_fifo_wreq, {r, g, b});
    end
    step();
    step();
  endtask

  task automatic test_nrst_async();
    setMode(2'd0, 1'b0);
    pushWord(32'h77777777);
    step();
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b1 || {r, g, b} !== 24'h777777) begin
      bad++;
      $display("[TB] FAIL nrst_pre: wreq=%b rgb=%h expected 1 777777", rgb_fifo_wreq, {r, g, b});
    end
    #1;
    nrst = 1'b0;
    #1;
    total++;
    if (rgb_fifo_wreq !== 1'b0 || {r, g, b} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL nrst_async: wreq=%b rgb=%h expected 0 0", rgb_fifo_wreq, {r, g, b});
    end
    nrst = 1'b1;
    step();
    total++;
    if (rgb_fifo_wreq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nrst_after: wreq=%b expected 0", rgb_fifo_wreq);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    nrst          = 1'b0;
    srst          = 1'b0;
    ColorDepth    = 2'd0;
    PseudoColor   = 1'b0;
    rgb_fifo_full = 1'b0;
    clut_ack      = 1'b0;
    clut_q        = 24'h0;
    popNow        = 1'b0;
    refreshVid();
    test_reset();
    test_grey8();
    test_rgb565();
    test_rgb24_straddle();
    test_xrgb32();
    test_pseudo_clut();
    test_fifo_full();
    test_srst_midstream();
    test_nrst_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_colproc_param.md
Name: vga_colproc_param

Overview:
- Parametrised colour processor; next generation of the VGA colour processor.
- Pops packed pixel words from the video-data buffer (show-ahead FIFO). Unpacks them MSB-first into pixels of 8/16/24/32 bpp and pushes 24-bit RGB into the RGB FIFO.
- New over the previous generation: configurable word width, a 32bpp mode, RGB565 bit-replication, and a handshaked CLUT port for 8bpp pseudo-colour with arbitrary latency.

Parameters:
- DATA_W, 32, video word width in bits; multiple of 32 (32 or 64).
- NB, DATA_W/8, derived bytes per word; not overridable.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high clear, e.g. at frame start.
- ColorDepth  in  2  0=8bpp, 1=16bpp RGB565, 2=24bpp, 3=32bpp xRGB.
- PseudoColor  in  1  8bpp only: 1 = CLUT lookup, 0 = greyscale.
- vdat_buffer_di  in  DATA_W  head word; valid while !vdat_buffer_empty.
- vdat_buffer_empty  in  1  video buffer empty.
- vdat_buffer_rreq  out  1  pop head word this cycle (combinational).
- rgb_fifo_full  in  1  RGB FIFO full; must assert with at least 1 entry of slack.
- rgb_fifo_wreq  out  1  registered write strobe.
- r, g, b  out  8 each  registered pixel, valid with rgb_fifo_wreq.
- clut_req  out  1  CLUT request; held until acknowledged.
- clut_offs  out  8  CLUT index; stable while clut_req is high.
- clut_ack  in  1  CLUT data valid.
- clut_q  in  24  CLUT data, {R,G,B}.

Behaviour:
- Reset: on nrst low, all state clears asynchronously. srst high clears the same state at the next edge. In both cases: rgb_fifo_wreq=0, clut_req=0, r/g/b=0, clut_offs=0, byte buffer empty (cnt=0), state IDLE.
- srst has priority over every other event. A pending CLUT request is abandoned; a late clut_ack is ignored.
- Mode inputs are static outside srst. A mode change without srst is undefined.
- Byte buffer: 2*NB bytes, cnt ranges 0..2*NB.
- BPP = 1/2/3/4 for ColorDepth 0/1/2/3.
- vdat_buffer_rreq = !vdat_buffer_empty && !srst && (cnt + NB - pop <= 2*NB). pop is the number of bytes consumed in the same cycle, so append and consume can happen together.
- Appended bytes go behind existing bytes; the word MSB byte comes first.
- cnt_next = cnt + (rreq ? NB : 0) - pop.
- Direct modes (not 8bpp pseudo):
  - If cnt >= BPP and !rgb_fifo_full: pop = BPP, and rgb_fifo_wreq=1 next cycle with the converted pixel. Otherwise rgb_fifo_wreq=0.
  - Throughput is 1 pixel/cycle. Latency from buffer pop to wreq is 1 cycle minimum.
- Conversions (byte0 = oldest byte):
  - 8bpp grey: r=g=b=byte0.
  - 16bpp: p={byte0,byte1}; r={p[15:11],p[15:13]}, g={p[10:5],p[10:9]}, b={p[4:0],p[4:2]}.
  - 24bpp: r=byte0, g=byte1, b=byte2.
  - 32bpp: byte0 discarded; r=byte1, g=byte2, b=byte3.
- Pseudo-colour FSM:
  - IDLE: if cnt >= 1 and !rgb_fifo_full, pop 1 byte, set clut_offs=byte0 and clut_req=1, go to WAIT.
  - WAIT: hold clut_req and clut_offs. On clut_ack: clut_req=0, {r,g,b}=clut_q, rgb_fifo_wreq=1 next cycle, return to IDLE.
  - clut_ack in the same cycle as the request edge is legal. The minimum request-to-request spacing is 2 cycles.
  - rgb_fifo_full is not re-checked in WAIT (slack requirement covers it).
- rgb_fifo_wreq is never asserted in the cycle after srst is high.
- Word boundaries: a pixel may straddle two words (24bpp with DATA_W=32); the buffer handles this with no bubble.
- Empty input: no pop and no wreq; state is held.

Decomposition:
- Package vga_colproc_pkg holds:
  - typedef enum for ColorDepth (CD_8, CD_16, CD_24, CD_32);
  - function bpp(cd) returning bytes per pixel;
  - FSM state enum {IDLE, WAIT};
  - function rgb565_expand.
- Sub-module vga_byte_unpacker, parameter DATA_W: byte buffer, cnt, rreq generation, and byte0..byte3 head view with a pop-count input.
- Conversion, FSM and output registers stay in the top level.

Test Plan:
- 8bpp grey, DATA_W=32, word 0x11223344, FIFO never full -> four consecutive wreq pulses with r=g=b = 0x11, 0x22, 0x33, 0x44.
- 16bpp, word 0xF80007E0 -> (r,g,b) = (FF,00,00) then (00,FF,00); word 0x001F -> (00,00,FF).
- 24bpp, words 0x11223344, 0x55667788, 0x99AABBCC -> pixels 112233, 445566, 778899, AABBCC on 4 consecutive wreqs; 32bpp, word 0xEE123456 -> 123456.
- Pseudo-colour, byte 0x05, clut_ack 3 cycles after the request, clut_q=0xABCDEF -> clut_req high 3 cycles with clut_offs=05, wreq one cycle after ack with r=AB, g=CD, b=EF; a second request never issues before IDLE.
- rgb_fifo_full high for 5 cycles during 24bpp streaming -> wreq low from the cycle after full is seen, no pixel lost or duplicated, stream resumes in order.
- srst asserted mid-stream and during WAIT -> wreq=0 and clut_req=0 next cycle, cnt=0, late clut_ack ignored. nrst pulsed asynchronously between edges -> outputs 0 immediately.
